// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared state encoding and constants for the ADC capture
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TURN = 3'd2,
        ST_RD_ADDR   = 3'd3,
        ST_RD_LATCH  = 3'd4,
        ST_SEND_LO   = 3'd5,
        ST_SEND_HI   = 3'd6,
        ST_DONE      = 3'd7
    } seq_state_t;

    localparam int          c_DIV_WIDTH   = 11;
    localparam logic [10:0] c_DEFAULT_DIV = 11'd4;

    // Two bytes per RAM word, addresses 0..sampling_num inclusive.
    function automatic int frame_bytes(input int sampling_num);
        return 2 * (sampling_num + 1);
    endfunction

    localparam int c_FRAME_BYTES = frame_bytes(1023);

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : timeout_counter
// Description : Cycle counter that flags expiry on its LIMIT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int               WIDTH = 24,
    parameter logic [WIDTH-1:0] LIMIT = WIDTH'(8_000_000)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is flagged during the cycle whose increment would reach LIMIT.
    assign expired = enable && (r_count == LIMIT - 1'b1);

endmodule
`default_nettype wire

// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_seq
// Description : Arms the ADC capture engine, waits for the RAM fill, then
//               streams the captured frame as bytes to the FT245 write path.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_seq
    import adc_pkg::*;
#(
    parameter int          DATA_WIDTH     = 9,
    parameter int          SAMPLING_NUM   = 1023,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CMD_START,
    input  logic                   CMD_CONT,
    input  logic                   CMD_ABORT,
    input  logic [c_DIV_WIDTH-1:0] CMD_DIV,
    output logic                   START_TURN,
    output logic [c_DIV_WIDTH-1:0] DIVIDER,
    input  logic                   TURN_DONE,
    output logic [DATA_WIDTH:0]    RAM_RD_ADDR,
    input  logic [15:0]            RAM_DATA_IN,
    output logic [7:0]             TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    output logic                   BUSY,
    output logic                   FRAME_DONE,
    output logic                   TIMEOUT_ERR
);

    localparam int                c_AW        = DATA_WIDTH + 1;
    localparam logic [c_AW-1:0]   c_LAST_ADDR = c_AW'(SAMPLING_NUM);

    seq_state_t  r_state;
    logic [15:0] r_word;
    logic        w_tmo_clear;
    logic        w_tmo_enable;
    logic        w_tmo_expired;

    // TURN_DONE suppresses the count so it wins over a coincident expiry.
    assign w_tmo_clear  = (r_state == ST_ARM);
    assign w_tmo_enable = (r_state == ST_WAIT_TURN) && !TURN_DONE;

    timeout_counter #(
        .WIDTH (24),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (w_tmo_clear),
        .enable  (w_tmo_enable),
        .expired (w_tmo_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            START_TURN  <= 1'b0;
            DIVIDER     <= c_DEFAULT_DIV;
            RAM_RD_ADDR <= '0;
            TX_DATA     <= '0;
            TX_VALID    <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            START_TURN <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (CMD_ABORT && (r_state != ST_IDLE)) begin
                r_state     <= ST_IDLE;
                TX_VALID    <= 1'b0;
                BUSY        <= 1'b0;
                RAM_RD_ADDR <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (CMD_START) begin
                            r_state     <= ST_ARM;
                            DIVIDER     <= CMD_DIV;
                            TIMEOUT_ERR <= 1'b0;
                            BUSY        <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        START_TURN <= 1'b1;
                        r_state    <= ST_WAIT_TURN;
                    end
                    ST_WAIT_TURN: begin
                        if (TURN_DONE) begin
                            r_state     <= ST_RD_ADDR;
                            RAM_RD_ADDR <= '0;
                        end else if (w_tmo_expired) begin
                            r_state     <= ST_IDLE;
                            TIMEOUT_ERR <= 1'b1;
                            BUSY        <= 1'b0;
                        end
                    end
                    ST_RD_ADDR: begin
                        r_state <= ST_RD_LATCH;
                    end
                    ST_RD_LATCH: begin
                        r_word   <= RAM_DATA_IN;
                        TX_DATA  <= RAM_DATA_IN[7:0];
                        TX_VALID <= 1'b1;
                        r_state  <= ST_SEND_LO;
                    end
                    ST_SEND_LO: begin
                        if (TX_READY) begin
                            TX_DATA <= r_word[15:8];
                            r_state <= ST_SEND_HI;
                        end else begin
                            TX_DATA <= r_word[7:0];
                        end
                    end
                    ST_SEND_HI: begin
                        if (TX_READY) begin
                            TX_VALID <= 1'b0;
                            if (RAM_RD_ADDR == c_LAST_ADDR) begin
                                r_state    <= ST_DONE;
                                FRAME_DONE <= 1'b1;
                            end else begin
                                RAM_RD_ADDR <= RAM_RD_ADDR + 1'b1;
                                r_state     <= ST_RD_ADDR;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (CMD_CONT) begin
                            r_state <= ST_ARM;
                            DIVIDER <= CMD_DIV;
                        end else begin
                            r_state <= ST_IDLE;
                            BUSY    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_seq.md
ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, RAM address MSB index (address width DATA_WIDTH+1).
REQ-002 SHALL have parameter SAMPLING_NUM, default 1023, last RAM address of one capture frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd8_000_000, max CLK cycles waited for TURN_DONE.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 CMD_START  input  1  one-cycle pulse requesting a capture frame.
REQ-007 CMD_CONT  input  1  1 = re-arm automatically after each frame is sent.
REQ-008 CMD_ABORT  input  1  one-cycle pulse; abandon current frame.
REQ-009 CMD_DIV  input  11  ADC divider value, sampled at frame start.
REQ-010 START_TURN  output  1  one-cycle pulse that starts the capture engine.
REQ-011 DIVIDER  output  11  divider held stable for the whole frame.
REQ-012 TURN_DONE  input  1  one-cycle pulse from capture engine: RAM filled.
REQ-013 RAM_RD_ADDR  output  DATA_WIDTH+1  capture RAM read address.
REQ-014 RAM_DATA_IN  input  16  capture RAM read data, valid one CLK after RAM_RD_ADDR.
REQ-015 TX_DATA  output  8  byte to FT245 write path.
REQ-016 TX_VALID  output  1  TX_DATA valid.
REQ-017 TX_READY  input  1  FT245 path accepts byte when TX_VALID and TX_READY both high.
REQ-018 BUSY  output  1  high in any state other than IDLE.
REQ-019 FRAME_DONE  output  1  one-cycle pulse after last byte accepted.
REQ-020 TIMEOUT_ERR  output  1  sticky; set on TURN_DONE timeout, cleared by next CMD_START.

Function
REQ-021 States SHALL be IDLE, ARM, WAIT_TURN, RD_ADDR, RD_LATCH, SEND_LO, SEND_HI, DONE.
REQ-022 IDLE -> ARM on CMD_START; DIVIDER <= CMD_DIV in the same edge.
REQ-023 ARM SHALL assert START_TURN for exactly one cycle, then -> WAIT_TURN with timeout counter cleared.
REQ-024 WAIT_TURN -> RD_ADDR on TURN_DONE, RAM_RD_ADDR <= 0; timeout counter increments each cycle otherwise.
REQ-025 Counter reaching TIMEOUT_CYCLES SHALL set TIMEOUT_ERR and -> IDLE, no FRAME_DONE.
REQ-026 RD_ADDR SHALL hold address one cycle; RD_LATCH captures RAM_DATA_IN into a 16-bit word register -> SEND_LO.
REQ-027 SEND_LO drives TX_DATA = word[7:0], TX_VALID=1; on TX_READY -> SEND_HI.
REQ-028 SEND_HI drives TX_DATA = word[15:8]; on TX_READY: if address == SAMPLING_NUM -> DONE, else address+1 -> RD_ADDR.
REQ-029 TX_DATA SHALL stay stable while TX_VALID high and TX_READY low; TX_VALID low outside SEND_LO/SEND_HI.
REQ-030 DONE SHALL pulse FRAME_DONE one cycle; -> ARM if CMD_CONT, else IDLE.
REQ-031 Frame SHALL be exactly 2*(SAMPLING_NUM+1) bytes (2048 at defaults), low byte first, addresses ascending.
REQ-032 CMD_ABORT in any non-IDLE state SHALL -> IDLE next cycle, TX_VALID low, no FRAME_DONE; abort wins over any simultaneous event.
REQ-033 CMD_START while BUSY SHALL be ignored.
REQ-034 TURN_DONE outside WAIT_TURN SHALL be ignored.
REQ-035 CMD_DIV changes during a frame SHALL not affect DIVIDER until next frame start.

Reset
REQ-036 On RST: state IDLE, START_TURN 0, DIVIDER 11'd4, RAM_RD_ADDR 0, TX_DATA 0, TX_VALID 0, BUSY 0, FRAME_DONE 0, TIMEOUT_ERR 0, counters 0.
REQ-037 RST mid-frame SHALL take effect on the next CLK edge with no partial byte or pulse emitted.

Structure
REQ-038 State encoding, default divider and frame byte count SHALL live in a shared package adc_pkg.
REQ-039 Timeout counter SHALL be a sub-module timeout_counter (clear, enable, expired).
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 CMD_START, CMD_DIV=9, TURN_DONE 50 cycles later, TX_READY=1 -> one START_TURN, DIVIDER=9, 2048 bytes, byte0=RAM[0][7:0], one FRAME_DONE.
REQ-042 TX_READY toggled randomly 50% -> byte order and values unchanged, TX_DATA stable during stalls.
REQ-043 No TURN_DONE, TIMEOUT_CYCLES=100 -> TIMEOUT_ERR at cycle 100 of WAIT_TURN, IDLE, no FRAME_DONE.
REQ-044 CMD_ABORT during SEND_HI of address 5 -> IDLE next cycle, TX_VALID 0, next CMD_START restarts at address 0.
REQ-045 CMD_CONT=1 -> second START_TURN exactly 2 cycles after FRAME_DONE; CMD_START while BUSY ignored.
REQ-046 RST asserted mid-WAIT_TURN -> all outputs at reset values after next edge.
